// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM state type for the sequential divider
package div_pkg;
  localparam int DW = 16;
  localparam int VW = 8;
  localparam int CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, shifts in a dividend bit and trial-subtracts the divisor
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);
  logic [VW+1:0] sh;
  // The full 2R+bit is kept so the compare also covers the top bit of R; it is always
  // zero for a nonzero divisor, and a zero divisor yields all-ones quotient regardless.
  assign sh      = {r_i, q_msb_i};
  assign q_bit_o = sh >= {2'b0, d_i};
  assign r_o     = q_bit_o ? (VW+1)'(sh - {2'b0, d_i}) : (VW+1)'(sh);
endmodule

// File: rtl/divider_16x8_seq.sv
// divider_16x8_seq: 16/8 restoring unsigned divider, one quotient bit per clock; DIV_ZERO_DETECT_EN enables early zero-divisor exit
module divider_16x8_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);
  state_e        state_q;
  logic [DW-1:0] q_q;
  logic [VW:0]   r_q;
  logic [VW-1:0] d_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [VW:0]   r_d;
  logic          q_bit_d;

  div_step #(.VW(VW)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (r_d),
    .q_bit_o (q_bit_d)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic div_zero_q;
  // Zero-divisor flag: set on an accepted zero divisor, cleared when the result is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_zero_q <= 1'b0;
    else if (state_q == IDLE && in_valid) div_zero_q <= divisor == '0;
    else if (state_q == DONE && out_ready) div_zero_q <= 1'b0;
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  // Control FSM and datapath: load operands, run DW restoring steps, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          q_q        <= dividend;
          d_q        <= divisor;
          r_q        <= '0;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= CALC;
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            q_q         <= '1;
            r_q         <= {1'b0, dividend[VW-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
`endif
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= {q_q[DW-2:0], q_bit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW-1)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = q_q;
  assign remainder = r_q[VW-1:0];
endmodule
